// File: rtl/raisin64_pkg.sv
// Shared constants and helpers for the raisin64 register-file writeback path.
// Provides register-file widths, the hardwired-zero register number and clog2.
package raisin64_pkg;

  localparam int RF_DW = 64;
  localparam int RF_RW = 6;

  localparam logic [RF_RW-1:0] RF_ZERO_RN = 6'd0;

  // Minimum bit width needed to index n items (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant over NREQ requesters.
// Ports: clk, rst_n, req_i (requests), en_i (grant enable), adv_i (advance
// pointer past idx_o), gnt_o (one-hot grant), idx_o (encoded grant index).
module rr_arbiter
  import raisin64_pkg::*;
#(
  parameter int NREQ = 3,
  localparam int IW = (clog2(NREQ) > 0) ? clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          found;
  int            c;

  // Search starts at the pointer and wraps; the first valid requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(ptr_q) + k;
      if (c >= NREQ) c = c - NREQ;
      if (en_i && !found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      if (idx_o == IW'(NREQ - 1)) ptr_d = '0;
      else                        ptr_d = idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port among NREQ writeback requesters
// with round-robin grant and registered write outputs (w_en/w_rn/w_data).
// Ports: clk, rst_n, wb_stall, req_valid/req_ready/req_rn/req_data (per
// requester, packed), w_en/w_rn/w_data (to rf), grant_id (last accepted).
// Build option RF_WB_FWD_EN adds fwd_valid/fwd_rn/fwd_data: the write
// committed at the previous edge, for read-port bypass.
module rf_wb_arbiter
  import raisin64_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = RF_DW,
  parameter int RW   = RF_RW,
  localparam int GW  = (clog2(NREQ) > 0) ? clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_stall,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*RW-1:0] req_rn,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               w_en,
  output logic [RW-1:0]      w_rn,
  output logic [DW-1:0]      w_data,
  output logic [GW-1:0]      grant_id
`ifdef RF_WB_FWD_EN
  ,
  output logic               fwd_valid,
  output logic [RW-1:0]      fwd_rn,
  output logic [DW-1:0]      fwd_data
`endif
);

  logic [NREQ-1:0] gnt;
  logic [GW-1:0]   gidx;
  logic [RW-1:0]   sel_rn;
  logic [DW-1:0]   sel_data;
  logic            xfer;
  logic            commit;

  logic            w_en_q;
  logic            w_en_d;
  logic [RW-1:0]   w_rn_q;
  logic [RW-1:0]   w_rn_d;
  logic [DW-1:0]   w_data_q;
  logic [DW-1:0]   w_data_d;
  logic [GW-1:0]   gid_q;
  logic [GW-1:0]   gid_d;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_valid),
    .en_i  (!wb_stall),
    .adv_i (xfer),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign sel_rn    = req_rn[int'(gidx)*RW +: RW];
  assign sel_data  = req_data[int'(gidx)*DW +: DW];

  // r0 writes are accepted but never reach the register file.
  assign commit = xfer && (sel_rn != RW'(RF_ZERO_RN));

  always_comb begin
    w_en_d   = commit;
    w_rn_d   = w_rn_q;
    w_data_d = w_data_q;
    gid_d    = gid_q;
    if (commit) begin
      w_rn_d   = sel_rn;
      w_data_d = sel_data;
    end
    if (xfer) gid_d = gidx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en_q   <= 1'b0;
      w_rn_q   <= '0;
      w_data_q <= '0;
      gid_q    <= '0;
    end else begin
      w_en_q   <= w_en_d;
      w_rn_q   <= w_rn_d;
      w_data_q <= w_data_d;
      gid_q    <= gid_d;
    end
  end

  assign w_en     = w_en_q;
  assign w_rn     = w_rn_q;
  assign w_data   = w_data_q;
  assign grant_id = gid_q;

`ifdef RF_WB_FWD_EN
  logic          fwd_valid_q;
  logic [RW-1:0] fwd_rn_q;
  logic [DW-1:0] fwd_data_q;

  // rf returns stale data when read and write share an edge, so the
  // write just committed is replayed for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_rn_q    <= '0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= w_en_q;
      if (w_en_q) begin
        fwd_rn_q   <= w_rn_q;
        fwd_data_q <= w_data_q;
      end
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_rn    = fwd_rn_q;
  assign fwd_data  = fwd_data_q;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_hold
    a_hold: assert property (
      @(posedge clk) disable iff (!rst_n)
      (req_valid[i] && !req_ready[i]) |=>
        ($stable(req_rn[i*RW +: RW]) && $stable(req_data[i*DW +: DW]))
    );
  end

  a_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(req_ready)
  );

  a_ready_valid: assert property (
    @(posedge clk) disable iff (!rst_n) ((req_ready & ~req_valid) == '0)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scoreboard bench for rf_wb_arbiter: driver pushes hand-computed
// write-port expectations, a monitor pops and compares after each edge.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 64;
  localparam int RW   = 6;
  localparam int GW   = 2;

  logic               clk;
  logic               rst_n;
  logic               wb_stall;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*RW-1:0] req_rn;
  logic [NREQ*DW-1:0] req_data;
  logic               w_en;
  logic [RW-1:0]      w_rn;
  logic [DW-1:0]      w_data;
  logic [GW-1:0]      grant_id;
`ifdef RF_WB_FWD_EN
  logic               fwd_valid;
  logic [RW-1:0]      fwd_rn;
  logic [DW-1:0]      fwd_data;
`endif

  rf_wb_arbiter #(
    .NREQ (NREQ),
    .DW   (DW),
    .RW   (RW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_stall  (wb_stall),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rn    (req_rn),
    .req_data  (req_data),
    .w_en      (w_en),
    .w_rn      (w_rn),
    .w_data    (w_data),
    .grant_id  (grant_id)
`ifdef RF_WB_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_rn    (fwd_rn),
    .fwd_data  (fwd_data)
`endif
  );

  typedef struct {
    logic          wen;
    logic [RW-1:0] rn;
    logic [DW-1:0] d;
    logic [GW-1:0] gid;
    logic          fv;
    logic [RW-1:0] frn;
    logic [DW-1:0] fd;
  } exp_t;

  exp_t          sbq[$];
  exp_t          prev;
  int            n_pass = 0;
  int            n_tot  = 0;
  logic [DW-1:0] rf_m [64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic set_req(input int i, input logic [RW-1:0] rn,
                         input logic [DW-1:0] d);
    req_rn[i*RW +: RW]   = rn;
    req_data[i*DW +: DW] = d;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic [2:0] v, input logic st,
                      input logic [2:0] er, input logic ew,
                      input logic [RW-1:0] ern, input logic [DW-1:0] ed,
                      input logic [GW-1:0] eg);
    exp_t e;
    req_valid = v;
    wb_stall  = st;
    #1;
    chk("req_ready", 64'(req_ready), 64'(er));
    e.wen = ew;
    e.rn  = ern;
    e.d   = ed;
    e.gid = eg;
    e.fv  = prev.wen;
    e.frn = prev.rn;
    e.fd  = prev.d;
    sbq.push_back(e);
    prev = e;
    @(negedge clk);
  endtask

  initial begin
    exp_t me;
    forever begin
      @(posedge clk);
      #1;
      if (w_en === 1'b1) rf_m[w_rn] = w_data;
      if (sbq.size() > 0) begin
        me = sbq.pop_front();
        chk("w_en", 64'(w_en), 64'(me.wen));
        chk("w_rn", 64'(w_rn), 64'(me.rn));
        chk("w_data", w_data, me.d);
        chk("grant_id", 64'(grant_id), 64'(me.gid));
`ifdef RF_WB_FWD_EN
        chk("fwd_valid", 64'(fwd_valid), 64'(me.fv));
        if (me.fv) begin
          chk("fwd_rn", 64'(fwd_rn), 64'(me.frn));
          chk("fwd_data", fwd_data, me.fd);
        end
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) rf_m[i] = '0;
    prev      = '{default: '0};
    rst_n     = 1'b0;
    wb_stall  = 1'b0;
    req_valid = 3'b111;
    req_rn    = '0;
    req_data  = '0;
    set_req(0, 6'd1, 64'h100);
    set_req(1, 6'd2, 64'h200);
    set_req(2, 6'd3, 64'h300);
    repeat (3) @(negedge clk);

    chk("rst w_en", 64'(w_en), 64'd0);
    chk("rst w_rn", 64'(w_rn), 64'd0);
    chk("rst w_data", w_data, 64'd0);
    chk("rst grant_id", 64'(grant_id), 64'd0);
`ifdef RF_WB_FWD_EN
    chk("rst fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst fwd_rn", 64'(fwd_rn), 64'd0);
    chk("rst fwd_data", fwd_data, 64'd0);
`endif

    rst_n = 1'b1;
    step(3'b111, 1'b0, 3'b001, 1'b1, 6'd1, 64'h100, 2'd0);
    step(3'b111, 1'b0, 3'b010, 1'b1, 6'd2, 64'h200, 2'd1);
    step(3'b111, 1'b0, 3'b100, 1'b1, 6'd3, 64'h300, 2'd2);
    step(3'b111, 1'b0, 3'b001, 1'b1, 6'd1, 64'h100, 2'd0);
    step(3'b111, 1'b0, 3'b010, 1'b1, 6'd2, 64'h200, 2'd1);
    step(3'b111, 1'b0, 3'b100, 1'b1, 6'd3, 64'h300, 2'd2);
    step(3'b000, 1'b0, 3'b000, 1'b0, 6'd3, 64'h300, 2'd2);

    set_req(1, 6'd5, 64'hDEAD_BEEF);
    step(3'b010, 1'b0, 3'b010, 1'b1, 6'd5, 64'hDEAD_BEEF, 2'd1);
    step(3'b000, 1'b0, 3'b000, 1'b0, 6'd5, 64'hDEAD_BEEF, 2'd1);

    set_req(2, 6'd0, 64'hFF);
    step(3'b100, 1'b0, 3'b100, 1'b0, 6'd5, 64'hDEAD_BEEF, 2'd2);
    step(3'b000, 1'b0, 3'b000, 1'b0, 6'd5, 64'hDEAD_BEEF, 2'd2);

    set_req(1, 6'd2, 64'h200);
    repeat (4)
      step(3'b011, 1'b1, 3'b000, 1'b0, 6'd5, 64'hDEAD_BEEF, 2'd2);
    step(3'b011, 1'b0, 3'b001, 1'b1, 6'd1, 64'h100, 2'd0);
    step(3'b011, 1'b0, 3'b010, 1'b1, 6'd2, 64'h200, 2'd1);
    step(3'b011, 1'b0, 3'b001, 1'b1, 6'd1, 64'h100, 2'd0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 6'd1, 64'h100, 2'd0);

    set_req(0, 6'd7, 64'h1234);
    step(3'b001, 1'b0, 3'b001, 1'b1, 6'd7, 64'h1234, 2'd0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 6'd7, 64'h1234, 2'd0);
    set_req(0, 6'd0, 64'hFF);
    step(3'b001, 1'b0, 3'b001, 1'b0, 6'd7, 64'h1234, 2'd0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 6'd7, 64'h1234, 2'd0);

    set_req(0, 6'd9, 64'hAA);
    set_req(1, 6'd9, 64'hBB);
    step(3'b011, 1'b0, 3'b010, 1'b1, 6'd9, 64'hBB, 2'd1);
    step(3'b011, 1'b0, 3'b001, 1'b1, 6'd9, 64'hAA, 2'd0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 6'd9, 64'hAA, 2'd0);

    set_req(0, 6'd1, 64'h100);
    set_req(1, 6'd2, 64'h200);
    set_req(2, 6'd3, 64'h300);
    step(3'b111, 1'b0, 3'b010, 1'b1, 6'd2, 64'h200, 2'd1);

    rst_n = 1'b0;
    #1;
    chk("midrst w_en", 64'(w_en), 64'd0);
    chk("midrst w_rn", 64'(w_rn), 64'd0);
    chk("midrst grant_id", 64'(grant_id), 64'd0);
    @(negedge clk);
    prev  = '{default: '0};
    rst_n = 1'b1;
    step(3'b000, 1'b0, 3'b000, 1'b0, 6'd0, 64'h0, 2'd0);
    step(3'b111, 1'b0, 3'b001, 1'b1, 6'd1, 64'h100, 2'd0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 6'd1, 64'h100, 2'd0);

    repeat (2) @(negedge clk);
    chk("sb drained", 64'(sbq.size()), 64'd0);
    chk("rf r9 later wins", rf_m[9], 64'hAA);
    chk("rf r5", rf_m[5], 64'hDEAD_BEEF);
    chk("rf r2", rf_m[2], 64'h200);
    chk("rf r0 untouched", rf_m[0], 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
